// File: rtl/result_display_pkg.sv
// rtl/result_display_pkg.sv - shared FSM state, iteration count and seven-segment patterns
package result_display_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LOAD  = 2'd2
   } state_t;

   localparam int ITER_COUNT = 8;

   // Active-low gfedcba with DP (bit 7) off
   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;

   function automatic logic [7:0] seg_pattern(input logic [3:0] digit);
      logic [7:0] pat;
      case (digit)
         4'd0:    pat = SEG_0;
         4'd1:    pat = SEG_1;
         4'd2:    pat = SEG_2;
         4'd3:    pat = SEG_3;
         4'd4:    pat = SEG_4;
         4'd5:    pat = SEG_5;
         4'd6:    pat = SEG_6;
         4'd7:    pat = SEG_7;
         4'd8:    pat = SEG_8;
         4'd9:    pat = SEG_9;
         default: pat = SEG_BLANK;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/result_display_bcd_to_seven_seg.sv
// rtl/result_display_bcd_to_seven_seg.sv - combinational BCD digit to active-low segment pattern
module bcd_to_seven_seg
   import result_display_pkg::*;
(
   input  logic [3:0] i_digit,
   input  logic       i_blank,
   input  logic       i_dp_on,
   output logic [7:0] o_seg
);

   logic [7:0] w_pat;

   // Decimal point stays independent of blanking so a flag is visible on an empty digit
   always_comb begin
      w_pat = i_blank ? SEG_BLANK : seg_pattern(i_digit);
      o_seg = {w_pat[7] & ~i_dp_on, w_pat[6:0]};
   end

endmodule

// File: rtl/result_display.sv
// rtl/result_display.sv - captures an 8-bit result, converts it to BCD and drives three seven-segment digits
module result_display
   import result_display_pkg::*;
#(
   parameter int BLINK_W = 24
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] value,
   input  logic       addSubOverflow,
   input  logic [1:0] multDivOverflow,
   output logic       busy,
   output logic       done,
   output logic [7:0] hex0,
   output logic [7:0] hex1,
   output logic [7:0] hex2
);

   state_t             r_state;
   logic [7:0]         r_bin;
   logic [11:0]        r_bcd;
   logic [3:0]         r_cnt;
   logic               r_aso;
   logic [1:0]         r_mdo;
   logic               r_ovf_disp;
   logic               r_loaded;
   logic [7:0]         r_pat0;
   logic [7:0]         r_pat1;
   logic [7:0]         r_pat2;
   logic [BLINK_W-1:0] r_blink_cnt;

   logic [11:0]        w_bcd_adj;
   logic               w_blank1;
   logic               w_blank2;
   logic               w_blink_off;
   logic [7:0]         w_seg0;
   logic [7:0]         w_seg1;
   logic [7:0]         w_seg2;

   always_comb begin
      w_bcd_adj = r_bcd;
      for (int i = 0; i < 3; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5)
            w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
   end

   assign w_blank2    = (r_bcd[11:8] == 4'd0);
   assign w_blank1    = w_blank2 && (r_bcd[7:4] == 4'd0);
   assign w_blink_off = r_ovf_disp & r_blink_cnt[BLINK_W-1];

   bcd_to_seven_seg u_dig0 (
      .i_digit (r_bcd[3:0]),
      .i_blank (1'b0),
      .i_dp_on (r_mdo[0]),
      .o_seg   (w_seg0)
   );

   bcd_to_seven_seg u_dig1 (
      .i_digit (r_bcd[7:4]),
      .i_blank (w_blank1),
      .i_dp_on (r_mdo[1]),
      .o_seg   (w_seg1)
   );

   bcd_to_seven_seg u_dig2 (
      .i_digit (r_bcd[11:8]),
      .i_blank (w_blank2),
      .i_dp_on (1'b0),
      .o_seg   (w_seg2)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         busy       <= 1'b0;
         r_bin      <= '0;
         r_bcd      <= '0;
         r_cnt      <= '0;
         r_aso      <= 1'b0;
         r_mdo      <= '0;
         r_ovf_disp <= 1'b0;
         r_loaded   <= 1'b0;
         r_pat0     <= SEG_BLANK;
         r_pat1     <= SEG_BLANK;
         r_pat2     <= SEG_BLANK;
      end else begin
         r_loaded <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_bin   <= value;
                  r_aso   <= addSubOverflow;
                  r_mdo   <= multDivOverflow;
                  r_bcd   <= '0;
                  r_cnt   <= '0;
                  busy    <= 1'b1;
                  r_state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
               r_cnt          <= r_cnt + 4'd1;
               if (r_cnt == 4'(ITER_COUNT - 1))
                  r_state <= ST_LOAD;
            end
            ST_LOAD: begin
               // Overflow flag travels with the pattern so a new capture cannot disturb the shown result
               r_pat0     <= w_seg0;
               r_pat1     <= w_seg1;
               r_pat2     <= w_seg2;
               r_ovf_disp <= r_aso;
               r_loaded   <= 1'b1;
               busy       <= 1'b0;
               r_state    <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_blink_cnt <= '0;
         done        <= 1'b0;
         hex0        <= SEG_BLANK;
         hex1        <= SEG_BLANK;
         hex2        <= SEG_BLANK;
      end else begin
         r_blink_cnt <= r_blink_cnt + 1'b1;
         done        <= r_loaded;
         hex0        <= w_blink_off ? SEG_BLANK : r_pat0;
         hex1        <= w_blink_off ? SEG_BLANK : r_pat1;
         hex2        <= w_blink_off ? SEG_BLANK : r_pat2;
      end
   end

endmodule
